// File: rtl/phys_reg_rename_unit.sv
// Rename stage state: arch->phys map table, per-preg ready bits and the physical-register
// free list. Decode renames sources and allocates destinations; the writeback-commit unit
// marks pregs ready on complete and returns stale pregs on commit.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   alloc_val/alloc_rdy            destination rename handshake
//   alloc_areg                     arch destination
//   alloc_preg, alloc_ppreg        new preg (free-list head) and previous mapping
//   rs1_areg/rs1_preg/rs1_pending  source 1 lookup
//   rs2_areg/rs2_preg/rs2_pending  source 2 lookup
//   complete_val/wen/preg          preg became ready
//   commit_val/wen/waddr/ppreg     stale preg to reclaim
//   free_count                     entries in the free list
module phys_reg_rename_unit #(
    parameter int unsigned p_phys_addr_bits = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_val,
    output logic                        alloc_rdy,
    input  logic [4:0]                  alloc_areg,
    output logic [p_phys_addr_bits-1:0] alloc_preg,
    output logic [p_phys_addr_bits-1:0] alloc_ppreg,
    input  logic [4:0]                  rs1_areg,
    output logic [p_phys_addr_bits-1:0] rs1_preg,
    output logic                        rs1_pending,
    input  logic [4:0]                  rs2_areg,
    output logic [p_phys_addr_bits-1:0] rs2_preg,
    output logic                        rs2_pending,
    input  logic                        complete_val,
    input  logic                        complete_wen,
    input  logic [p_phys_addr_bits-1:0] complete_preg,
    input  logic                        commit_val,
    input  logic                        commit_wen,
    input  logic [4:0]                  commit_waddr,
    input  logic [p_phys_addr_bits-1:0] commit_ppreg,
    output logic [p_phys_addr_bits:0]   free_count
);

    localparam int unsigned P  = p_phys_addr_bits;
    localparam int unsigned NP = 2 ** P;

    // Reset free list holds pregs 32..NP-1: head at 32, tail one lap-wrapped at index 0.
    localparam logic [P:0] HeadInit = (P+1)'(32);
    localparam logic [P:0] TailInit = (P+1)'(NP);

    logic [P-1:0]  map_q [32];
    logic [NP-1:0] ready_q;
    logic [P-1:0]  fl_q [NP];
    logic [P:0]    head_q;
    logic [P:0]    tail_q;

    logic          alloc_fire;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          fl_full;
    logic          complete_hit;

    always_comb begin
        free_count   = tail_q - head_q;
        fl_full      = (free_count == (P+1)'(NP));
        alloc_rdy    = (alloc_areg == 5'd0) || (free_count != '0);
        alloc_fire   = alloc_val && alloc_rdy;
        pop          = alloc_fire && (alloc_areg != 5'd0);
        push_req     = commit_val && commit_wen && (commit_waddr != 5'd0);
        push         = push_req && !fl_full;
        complete_hit = complete_val && complete_wen;

        alloc_preg  = '0;
        alloc_ppreg = '0;
        if (alloc_areg != 5'd0) begin
            alloc_preg  = fl_q[head_q[P-1:0]];
            alloc_ppreg = map_q[alloc_areg];
        end

        // Lookups see the map before this cycle's allocation lands.
        rs1_preg    = map_q[rs1_areg];
        rs2_preg    = map_q[rs2_areg];
        rs1_pending = (rs1_areg != 5'd0) && !ready_q[rs1_preg] &&
                      !(complete_hit && (complete_preg == rs1_preg));
        rs2_pending = (rs2_areg != 5'd0) && !ready_q[rs2_preg] &&
                      !(complete_hit && (complete_preg == rs2_preg));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                map_q[i] <= P'(i);
            end
            for (int i = 0; i < NP; i++) begin
                fl_q[i] <= P'(i);
            end
            ready_q <= '1;
            head_q  <= HeadInit;
            tail_q  <= TailInit;
        end else begin
            if (complete_hit) begin
                ready_q[complete_preg] <= 1'b1;
            end
            // Written after the complete update so a colliding allocation wins.
            if (pop) begin
                ready_q[alloc_preg] <= 1'b0;
                map_q[alloc_areg]   <= alloc_preg;
                head_q              <= head_q + 1'b1;
            end
            if (push) begin
                fl_q[tail_q[P-1:0]] <= commit_ppreg;
                tail_q              <= tail_q + 1'b1;
            end
        end
    end

    push_while_full: assert property (@(posedge clk) disable iff (rst) !(push_req && fl_full));

`ifndef SYNTHESIS
    // "areg>preg" on alloc fire, "+preg" on reclaim; level>0 pads to a fixed column width.
    function automatic string trace(input int level);
        string s;
        s = "";
        if (pop) begin
            s = $sformatf("%0d>%0d", alloc_areg, alloc_preg);
        end
        if (push) begin
            s = {s, (s.len() != 0) ? " " : "", $sformatf("+%0d", commit_ppreg)};
        end
        if (level > 0) begin
            while (s.len() < 12) begin
                s = {s, " "};
            end
        end
        return s;
    endfunction
`endif

endmodule

// File: tb/tb_phys_reg_rename_unit.sv
module tb_phys_reg_rename_unit;

    localparam int P  = 6;
    localparam int NP = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_val;
    logic         alloc_rdy;
    logic [4:0]   alloc_areg;
    logic [P-1:0] alloc_preg;
    logic [P-1:0] alloc_ppreg;
    logic [4:0]   rs1_areg;
    logic [P-1:0] rs1_preg;
    logic         rs1_pending;
    logic [4:0]   rs2_areg;
    logic [P-1:0] rs2_preg;
    logic         rs2_pending;
    logic         complete_val;
    logic         complete_wen;
    logic [P-1:0] complete_preg;
    logic         commit_val;
    logic         commit_wen;
    logic [4:0]   commit_waddr;
    logic [P-1:0] commit_ppreg;
    logic [P:0]   free_count;

    always #5 clk = ~clk;

    phys_reg_rename_unit #(.p_phys_addr_bits(P)) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_val     (alloc_val),
        .alloc_rdy     (alloc_rdy),
        .alloc_areg    (alloc_areg),
        .alloc_preg    (alloc_preg),
        .alloc_ppreg   (alloc_ppreg),
        .rs1_areg      (rs1_areg),
        .rs1_preg      (rs1_preg),
        .rs1_pending   (rs1_pending),
        .rs2_areg      (rs2_areg),
        .rs2_preg      (rs2_preg),
        .rs2_pending   (rs2_pending),
        .complete_val  (complete_val),
        .complete_wen  (complete_wen),
        .complete_preg (complete_preg),
        .commit_val    (commit_val),
        .commit_wen    (commit_wen),
        .commit_waddr  (commit_waddr),
        .commit_ppreg  (commit_ppreg),
        .free_count    (free_count)
    );

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model: plain queue free list, map and ready arrays.
    int   map_m [32];
    bit   rdy_m [NP];
    int   fl_m[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            0:       return int'(alloc_rdy);
            1:       return int'(alloc_preg);
            2:       return int'(alloc_ppreg);
            3:       return int'(rs1_preg);
            4:       return int'(rs1_pending);
            5:       return int'(rs2_preg);
            6:       return int'(rs2_pending);
            default: return int'(free_count);
        endcase
    endfunction

    task automatic exp_push(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic int pend_m(input int a, input int p);
        return int'(a != 0 && !rdy_m[p] &&
                    !(complete_val && complete_wen && int'(complete_preg) == p));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) map_m[i] = i;
        for (int i = 0; i < NP; i++) rdy_m[i] = 1'b1;
        fl_m.delete();
        for (int i = 32; i < NP; i++) fl_m.push_back(i);
    endtask

    task automatic model_step();
        int  p;
        bit  full;
        if (rst) begin
            model_reset();
            return;
        end
        full = (fl_m.size() == NP);
        if (complete_val && complete_wen) rdy_m[complete_preg] = 1'b1;
        if (alloc_val && alloc_areg != 0 && fl_m.size() != 0) begin
            p = fl_m.pop_front();
            map_m[alloc_areg] = p;
            rdy_m[p] = 1'b0;
        end
        if (commit_val && commit_wen && commit_waddr != 0 && !full) begin
            fl_m.push_back(int'(commit_ppreg));
        end
    endtask

    // Inputs are already driven (just after negedge); queue expectations, compare, advance.
    task automatic do_cycle(input string tag);
        exp_t e;
        int   cnt;
        int   p1;
        int   p2;
        #1;
        if (!rst) begin
            cnt = fl_m.size();
            exp_push({tag, ".rdy"}, 0, int'(alloc_areg == 0 || cnt != 0));
            if (alloc_areg == 0) begin
                exp_push({tag, ".preg"}, 1, 0);
                exp_push({tag, ".ppreg"}, 2, 0);
            end else begin
                if (cnt != 0) exp_push({tag, ".preg"}, 1, fl_m[0]);
                exp_push({tag, ".ppreg"}, 2, map_m[alloc_areg]);
            end
            p1 = map_m[rs1_areg];
            p2 = map_m[rs2_areg];
            exp_push({tag, ".rs1"}, 3, p1);
            exp_push({tag, ".rs1p"}, 4, pend_m(int'(rs1_areg), p1));
            exp_push({tag, ".rs2"}, 5, p2);
            exp_push({tag, ".rs2p"}, 6, pend_m(int'(rs2_areg), p2));
            exp_push({tag, ".cnt"}, 7, cnt);
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sel), e.val);
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        alloc_val = 0; alloc_areg = 0; rs1_areg = 0; rs2_areg = 0;
        complete_val = 0; complete_wen = 0; complete_preg = 0;
        commit_val = 0; commit_wen = 0; commit_waddr = 0; commit_ppreg = 0;
        model_reset();
        @(negedge clk);
        do_cycle("rst0");
        do_cycle("rst1");
        rst = 1'b0;

        // Reset state
        rs1_areg = 5; alloc_areg = 3;
        exp_push("reset.cnt", 7, 32);
        exp_push("reset.rs1", 3, 5);
        exp_push("reset.rs1p", 4, 0);
        exp_push("reset.preg", 1, 32);
        exp_push("reset.ppreg", 2, 3);
        do_cycle("reset");

        // Drain the whole list into x1
        alloc_val = 1; alloc_areg = 1; rs1_areg = 1; rs2_areg = 3;
        for (int k = 0; k < 32; k++) begin
            exp_push("fill.preg", 1, 32 + k);
            exp_push("fill.ppreg", 2, (k == 0) ? 1 : 31 + k);
            do_cycle("fill");
        end
        exp_push("empty.rdy", 0, 0);
        exp_push("empty.cnt", 7, 0);
        do_cycle("empty");

        // x0 never needs a preg
        alloc_areg = 0;
        exp_push("x0.preg", 1, 0);
        exp_push("x0.rdy", 0, 1);
        do_cycle("x0");
        alloc_val = 0;
        exp_push("x0.cnt", 7, 0);
        do_cycle("x0_after");

        // Commit with wen=0 reclaims nothing
        commit_val = 1; commit_wen = 0; commit_waddr = 1; commit_ppreg = 5;
        do_cycle("nowen");

        // Reclaim preg 1, no same-cycle bypass
        commit_wen = 1; commit_ppreg = 1; alloc_val = 1; alloc_areg = 1;
        exp_push("nobyp.rdy", 0, 0);
        do_cycle("nobyp");
        commit_val = 0;
        exp_push("reclaim.cnt", 7, 1);
        exp_push("reclaim.preg", 1, 1);
        do_cycle("reclaim");
        alloc_val = 0;
        do_cycle("reclaim_after");

        // Mid-run reset
        rst = 1'b1;
        do_cycle("rst_mid");
        rst = 1'b0;
        exp_push("rstmid.cnt", 7, 32);
        exp_push("rstmid.preg", 1, 32);
        exp_push("rstmid.rs1", 3, 1);
        exp_push("rstmid.rs1p", 4, 0);
        do_cycle("rstmid");

        // Alloc x4, read it back, complete it
        alloc_val = 1; alloc_areg = 4; rs1_areg = 4; rs2_areg = 0;
        exp_push("x4.rs1_old", 3, 4);
        do_cycle("x4");
        alloc_val = 0;
        exp_push("x4.rs1", 3, 32);
        exp_push("x4.rs1p", 4, 1);
        exp_push("x4.rs2p", 6, 0);
        do_cycle("x4_pend");
        complete_val = 1; complete_wen = 1; complete_preg = 32;
        exp_push("cmpl.rs1p", 4, 0);
        do_cycle("cmpl");
        complete_val = 0;
        exp_push("cmpl_after.rs1p", 4, 0);
        do_cycle("cmpl_after");

        // Bring count down to 10
        alloc_val = 1; alloc_areg = 8; rs2_areg = 8;
        for (int k = 0; k < 21; k++) do_cycle("to10");

        // Pop and push together
        alloc_areg = 7;
        commit_val = 1; commit_wen = 1; commit_waddr = 7; commit_ppreg = 40;
        exp_push("pp.cnt", 7, 10);
        do_cycle("pp");
        commit_val = 0; alloc_val = 0;
        exp_push("pp_after.cnt", 7, 10);
        do_cycle("pp_after");

        // Reclaimed 40 comes out last
        alloc_val = 1; alloc_areg = 9;
        for (int k = 0; k < 10; k++) begin
            exp_push("tail.preg", 1, (k < 9) ? 55 + k : 40);
            do_cycle("tail");
        end
        exp_push("tail_end.rdy", 0, 0);
        exp_push("tail_end.cnt", 7, 0);
        do_cycle("tail_end");
        alloc_val = 0;
        do_cycle("idle");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
